// File: rtl/riscv_ap_pkg.sv
// Shared types for the risc-v_ap core: register address, data word, write-back entry.
package riscv_ap_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

  typedef struct packed {
    reg_addr_t rd;
    xlen_t     data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back entries; DEPTH must be a power of two (pointers wrap naturally).
module wb_fifo
  import riscv_ap_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t din,
  input  logic      pop,
  output wb_entry_t dout,
  output logic      full,
  output logic      empty
);
  localparam int AW = $clog2(DEPTH);

  wb_entry_t         mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible behind the count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/wb_unit.sv
// Write-back stage: ALU/LSU merge into the register-file write port plus pending-load scoreboard.
// Optional WB_LSU_BYPASS_EN: LSU result skips the empty FIFO straight into the output register.
module wb_unit
  import riscv_ap_pkg::*;
#(
  parameter int LSU_FIFO_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  alu_valid_i,
  input  logic [REG_ADDR_W-1:0] alu_rd_i,
  input  logic [XLEN-1:0]       alu_data_i,
  input  logic                  lsu_valid_i,
  output logic                  lsu_ready_o,
  input  logic [REG_ADDR_W-1:0] lsu_rd_i,
  input  logic [XLEN-1:0]       lsu_data_i,
  input  logic                  ld_issue_i,
  input  logic [REG_ADDR_W-1:0] ld_rd_i,
  input  logic [REG_ADDR_W-1:0] rs1_add_i,
  input  logic [REG_ADDR_W-1:0] rs2_add_i,
  output logic                  hazard_o,
  output logic                  we_o,
  output logic [REG_ADDR_W-1:0] rd_add_o,
  output logic [XLEN-1:0]       rd_data_o
);
  localparam int NREG = 1 << REG_ADDR_W;

  wb_entry_t       head, lsu_ent, sel;
  logic            full, empty, accept, push, pop, bypass;
  logic            sel_vld, sel_lsu, out_is_lsu;
  logic [NREG-1:0] pending, pend_nxt;

  assign lsu_ent     = '{rd: lsu_rd_i, data: lsu_data_i};
  assign lsu_ready_o = ~full;
  assign accept      = lsu_valid_i & lsu_ready_o;
  assign pop         = ~alu_valid_i & ~empty;

`ifdef WB_LSU_BYPASS_EN
  assign bypass = accept & empty & ~alu_valid_i;
`else
  assign bypass = 1'b0;
`endif
  assign push = accept & ~bypass;

  wb_fifo #(.DEPTH(LSU_FIFO_DEPTH)) u_fifo (
    .clk   (clk_i),
    .rst_n (rstn_i),
    .push  (push),
    .din   (lsu_ent),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // ALU has strict priority; FIFO head next; bypass only when both are idle.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    sel_lsu = 1'b0;
    if (alu_valid_i) begin
      sel     = '{rd: alu_rd_i, data: alu_data_i};
      sel_vld = 1'b1;
    end else if (pop) begin
      sel     = head;
      sel_vld = 1'b1;
      sel_lsu = 1'b1;
    end else if (bypass) begin
      sel     = lsu_ent;
      sel_vld = 1'b1;
      sel_lsu = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      we_o       <= 1'b0;
      rd_add_o   <= '0;
      rd_data_o  <= '0;
      out_is_lsu <= 1'b0;
    end else begin
      we_o       <= sel_vld & (sel.rd != '0);
      out_is_lsu <= sel_vld & sel_lsu;
      if (sel_vld) begin
        rd_add_o  <= sel.rd;
        rd_data_o <= sel.data;
      end
    end
  end

  // Clear follows the register-file write of a load; a same-edge issue to that index wins.
  always_comb begin
    pend_nxt = pending;
    if (we_o & out_is_lsu)               pend_nxt[rd_add_o] = 1'b0;
    if (ld_issue_i && (ld_rd_i != '0))   pend_nxt[ld_rd_i]  = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) pending <= '0;
    else         pending <= pend_nxt;
  end

  assign hazard_o = ((rs1_add_i != '0) & pending[rs1_add_i]) |
                    ((rs2_add_i != '0) & pending[rs2_add_i]);
endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: directed scenarios plus random traffic against a queue model.
module tb_wb_unit;
  import riscv_ap_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0, rstn = 1'b0;
  logic        alu_valid = 0, lsu_valid = 0, ld_issue = 0;
  logic [4:0]  alu_rd = 0, lsu_rd = 0, ld_rd = 0, rs1 = 0, rs2 = 0;
  logic [31:0] alu_data = 0, lsu_data = 0;
  logic        lsu_ready, hazard, we;
  logic [4:0]  rd_add;
  logic [31:0] rd_data;

  wb_unit #(.LSU_FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .alu_valid_i(alu_valid), .alu_rd_i(alu_rd), .alu_data_i(alu_data),
    .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready), .lsu_rd_i(lsu_rd), .lsu_data_i(lsu_data),
    .ld_issue_i(ld_issue), .ld_rd_i(ld_rd),
    .rs1_add_i(rs1), .rs2_add_i(rs2), .hazard_o(hazard),
    .we_o(we), .rd_add_o(rd_add), .rd_data_o(rd_data)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Model state: buffered loads, expected write port, pending set.
  wb_entry_t   m_q[$];
  bit          m_we, m_lsu, m_acc;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  bit [31:0]   m_pend;

  function automatic void model_reset();
    m_q.delete();
    m_we = 0; m_lsu = 0; m_acc = 0; m_rd = 0; m_data = 0; m_pend = 0;
  endfunction

  function automatic void model_step();
    bit sel = 0, sl = 0, byp = 0, acc;
    wb_entry_t e = '0;
    acc = lsu_valid && (m_q.size() < DEPTH);
    if (alu_valid) begin
      sel = 1; e = '{rd: alu_rd, data: alu_data};
    end else if (m_q.size() > 0) begin
      sel = 1; sl = 1; e = m_q.pop_front();
    end
`ifdef WB_LSU_BYPASS_EN
    else if (acc) begin
      sel = 1; sl = 1; byp = 1; e = '{rd: lsu_rd, data: lsu_data};
    end
`endif
    if (acc && !byp) m_q.push_back('{rd: lsu_rd, data: lsu_data});
    if (m_we && m_lsu) m_pend[m_rd] = 0;
    if (ld_issue && ld_rd != 0) m_pend[ld_rd] = 1;
    m_we  = sel && (e.rd != 0);
    m_lsu = sel && sl;
    if (sel) begin m_rd = e.rd; m_data = e.data; end
    m_acc = acc;
  endfunction

  function automatic bit exp_hazard();
    return (rs1 != 0 && m_pend[rs1]) || (rs2 != 0 && m_pend[rs2]);
  endfunction

  // One clock: combinational checks mid-cycle, model advance, registered checks after the edge.
  task automatic tick();
    @(negedge clk);
    chk("lsu_ready", lsu_ready, (m_q.size() < DEPTH));
    chk("hazard", hazard, exp_hazard());
    model_step();
    @(posedge clk);
    #1;
    chk("we", we, m_we);
    chk("rd_add", rd_add, m_rd);
    chk("rd_data", rd_data, m_data);
  endtask

  task automatic idle();
    alu_valid = 0; lsu_valid = 0; ld_issue = 0; rs1 = 0; rs2 = 0;
  endtask

  int li;
  logic [4:0]  lrd [3];
  logic [31:0] ldat[3];
  bit hold;

  initial begin
    model_reset();
    #1;
    chk("rst_we", we, 0);
    chk("rst_rd", rd_add, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_hazard", hazard, 0);
    @(negedge clk); @(negedge clk);
    rstn = 1;
    #1;
    chk("rst_ready", lsu_ready, 1);

    // ALU only
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    tick();
    chk("alu_we", we, 1); chk("alu_rd", rd_add, 5); chk("alu_data", rd_data, 32'hDEADBEEF);
    idle();
    tick();
    chk("alu_idle_we", we, 0);

    // Load flow
    ld_issue = 1; ld_rd = 7;
    tick();
    ld_issue = 0; rs1 = 7; #1;
    chk("ld_hazard", hazard, 1);
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h12345678;
    tick();
    lsu_valid = 0;
`ifndef WB_LSU_BYPASS_EN
    chk("ld_lat1_we", we, 0);
    tick();
`endif
    chk("ld_we", we, 1); chk("ld_rd", rd_add, 7); chk("ld_data", rd_data, 32'h12345678);
    tick();
    chk("ld_hazard_clr", hazard, 0);
    idle();

    // ALU/LSU conflict
    alu_valid = 1; alu_rd = 3; alu_data = 1;
    lsu_valid = 1; lsu_rd = 4; lsu_data = 2;
    tick();
    idle();
    chk("cf_first", rd_add, 3);
    tick();
    chk("cf_second_we", we, 1); chk("cf_second", rd_add, 4); chk("cf_second_d", rd_data, 2);

    // Backpressure: ALU busy for 4 cycles, 3 LSU results held until accepted
    for (int i = 0; i < 3; i++) begin lrd[i] = 5'(10 + i); ldat[i] = 32'hA000 + i; end
    li = 0;
    for (int c = 0; c < 12; c++) begin
      alu_valid = (c < 4); alu_rd = 5'(20 + c); alu_data = 32'hB000 + c;
      lsu_valid = (li < 3);
      if (li < 3) begin lsu_rd = lrd[li]; lsu_data = ldat[li]; end
      if (c == 2) begin #1; chk("bp_ready_low", lsu_ready, 0); end
      tick();
      if (m_acc) li++;
    end
    chk("bp_all_accepted", li, 3);
    idle();

    // rd = 0 on both paths; load issue to x0
    alu_valid = 1; alu_rd = 0; alu_data = 32'h55;
    lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h66;
    ld_issue = 1; ld_rd = 0;
    tick();
    chk("x0_alu_we", we, 0);
    idle();
    tick();
    chk("x0_lsu_we", we, 0);
    tick();

    // Reset with 2 entries buffered and pending[9] set
    alu_valid = 1; alu_rd = 1; alu_data = 1;
    lsu_valid = 1; lsu_rd = 12; lsu_data = 32'hC0;
    ld_issue = 1; ld_rd = 9;
    tick();
    ld_issue = 0; lsu_rd = 13; lsu_data = 32'hC1;
    tick();
    lsu_valid = 0; rs1 = 9; #1;
    chk("pre_rst_hazard", hazard, 1);
    rstn = 0; #1;
    chk("mid_rst_we", we, 0);
    chk("mid_rst_hazard", hazard, 0);
    idle();
    model_reset();
    @(negedge clk);
    rstn = 1; #1;
    chk("post_rst_ready", lsu_ready, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_nowrite", we, 0);
    end

    // Random traffic; LSU holds its result until accepted
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      alu_valid = ($urandom_range(2) == 0);
      alu_rd    = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
      alu_data  = $urandom;
      if (!hold) begin
        lsu_valid = ($urandom_range(1) == 0);
        lsu_rd    = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
        lsu_data  = $urandom;
      end
      ld_issue = ($urandom_range(3) == 0);
      ld_rd    = 5'($urandom);
      rs1      = 5'($urandom);
      rs2      = 5'($urandom);
      tick();
      hold = lsu_valid && !m_acc;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_unit.md
Name: wb_unit

Overview:
- Write-back stage of the risc-v_ap core; the single writer that drives the register file's write port (we/rd address/rd data).
- Merges single-cycle ALU results with multi-cycle LSU load results.
- Buffers LSU results in a small FIFO.
- Keeps a pending-load scoreboard, which decode queries to detect load-use hazards on rs1/rs2.

Parameters:
XLEN, 32, data width of results and register file
REG_ADDR_W, 5, register address width (32 registers)
LSU_FIFO_DEPTH, 2, LSU result FIFO entries (power of 2, >=2)

Ports:
clk_i  in  1  clock, all state updates on rising edge
rstn_i  in  1  asynchronous active-low reset
alu_valid_i  in  1  ALU result valid this cycle (no backpressure)
alu_rd_i  in  REG_ADDR_W  ALU destination register
alu_data_i  in  XLEN  ALU result
lsu_valid_i  in  1  LSU load result valid
lsu_ready_o  out  1  wb_unit can accept LSU result
lsu_rd_i  in  REG_ADDR_W  load destination register
lsu_data_i  in  XLEN  load data
ld_issue_i  in  1  a load is issued; marks ld_rd_i pending
ld_rd_i  in  REG_ADDR_W  destination of issued load
rs1_add_i  in  REG_ADDR_W  decode source 1 address
rs2_add_i  in  REG_ADDR_W  decode source 2 address
hazard_o  out  1  rs1 or rs2 targets a pending load
we_o  out  1  register file write enable
rd_add_o  out  REG_ADDR_W  register file write address
rd_data_o  out  XLEN  register file write data

Behaviour:
- Reset (async, rstn_i low):
  - we_o=0, rd_add_o=0, rd_data_o=0.
  - FIFO emptied; lsu_ready_o=1 once reset is released.
  - Pending vector cleared; hazard_o=0.
  - Reset mid-operation discards all buffered results.
- LSU handshake:
  - Push when lsu_valid_i & lsu_ready_o.
  - lsu_ready_o = !fifo_full, registered-state-derived with no combinational path from lsu_valid_i.
  - LSU must hold valid/rd/data until accepted.
- Arbitration, one write per cycle:
  - ALU has strict priority.
  - FIFO head is popped only when alu_valid_i=0 and the FIFO is not empty.
- Output register, 1-cycle latency:
  - On each edge, load we_o/rd_add_o/rd_data_o from the selected source.
  - If nothing is selected, we_o=0; rd_add_o/rd_data_o hold.
  - Track a registered flag out_is_lsu.
- rd = 0: the entry is consumed (popped or ALU cycle used), but we_o=0 for it.
- LSU latency: accepted result reaches we_o 2 cycles after acceptance (FIFO write, then pop), minimum, when not blocked by ALU.
- Full FIFO: lsu_ready_o=0; no push.
  - Push and pop in the same cycle on a full FIFO is not allowed (ready already low).
  - On a non-full FIFO, simultaneous push+pop keeps the count unchanged.
- Pointers wrap modulo LSU_FIFO_DEPTH; count is width clog2(DEPTH)+1.
- Scoreboard (pending[31:0]):
  - Set pending[ld_rd_i] on ld_issue_i when ld_rd_i != 0.
  - Clear pending[rd_add_o] on the edge where we_o & out_is_lsu. The register file samples the same write on that edge.
  - Same index set and cleared on one edge: set wins.
  - pending[0] is always 0.
- hazard_o (combinational) = (rs1_add_i!=0 & pending[rs1_add_i]) | (rs2_add_i!=0 & pending[rs2_add_i]).
- No forwarding: the cycle after the clearing edge, hazard_o=0 and the register file returns the new value.
- ALU write to a register with a pending load is not detected here; issue logic guarantees no WAW.

Optional Feature:
- WB_LSU_BYPASS_EN defined:
  - When the FIFO is empty and alu_valid_i=0, an accepted LSU result goes directly to the output register on the acceptance edge (no FIFO write).
  - LSU latency becomes 1 cycle.
- WB_LSU_BYPASS_EN undefined: all LSU results pass through the FIFO (2-cycle minimum latency).
- Scoreboard rules are identical in both cases.

Decomposition:
- Shared package riscv_ap_pkg: XLEN, REG_ADDR_W, typedef reg_addr_t, typedef xlen_t, typedef wb_entry_t (struct {reg_addr_t rd; xlen_t data;}).
- One sub-module: wb_fifo, a parameterised synchronous FIFO of wb_entry_t with full/empty flags and async active-low reset.
- Scoreboard and arbiter stay in wb_unit.

Test Plan:
- ALU only: alu_valid_i=1, rd=5, data=0xDEADBEEF -> next cycle we_o=1, rd_add_o=5, rd_data_o=0xDEADBEEF; following idle cycle we_o=0.
- Load flow: ld_issue_i rd=7; rs1_add_i=7 -> hazard_o=1. LSU rd=7, data=0x12345678 accepted -> we_o=1 with rd 7 two cycles later (one with WB_LSU_BYPASS_EN). hazard_o=0 the cycle after.
- Conflict: ALU (rd=3, 0x1) and LSU (rd=4, 0x2) valid on the same cycle -> rd 3 written first, rd 4 on the next cycle.
- Backpressure: alu_valid_i=1 for 4 cycles while LSU presents 3 results -> lsu_ready_o=0 after 2 accepted. Third result accepted after ALU stops. All three written in order with no loss.
- rd=0: ALU and LSU results to x0 -> we_o stays 0; FIFO drains; ld_issue_i with rd 0 never raises hazard_o.
- Reset mid-operation: FIFO holding 2 entries, pending[9]=1, assert rstn_i -> we_o=0 immediately, hazard_o=0, lsu_ready_o=1 after release, no stale writes.
